// File: rtl/sd_dat_tx.sv
// Single-line (DAT0) SD write-block transmitter: start bit, MSB-first block data,
// CRC16 and end bit, then the card's CRC-status token and busy wait.
module sd_dat_tx #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned TIMEOUT     = 65535,
  localparam int unsigned AW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          istart,
  output logic [AW-1:0] odata_addr,
  input  logic [7:0]    idata_byte,
  output logic          odat,
  output logic          odat_oe,
  input  logic          idat,
  output logic          obusy,
  output logic          odone,
  output logic          oerr
);

  localparam int unsigned BW = AW + 3;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] AMAX     = AW'(BLOCK_BYTES - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(8 * BLOCK_BYTES - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, START, DATA, CRC, END, NCRC, WAIT_STAT, STAT, BUSY, DONE
  } state_t;

  state_t        state, nstate;
  logic [BW-1:0] bitcnt;
  logic [3:0]    cnt;
  logic [TW-1:0] tcnt;
  logic [7:0]    shreg;
  logic [15:0]   crc, crc_next, crcsh;
  logic [2:0]    stat;
  logic          err;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate  = state;
    odat    = 1'b1;
    odat_oe = 1'b0;
    case (state)
      IDLE:      if (istart) nstate = START;
      START: begin
        odat    = 1'b0;
        odat_oe = 1'b1;
        nstate  = DATA;
      end
      DATA: begin
        odat    = shreg[7];
        odat_oe = 1'b1;
        if (bitcnt == LAST_BIT) nstate = CRC;
      end
      CRC: begin
        odat    = crcsh[15];
        odat_oe = 1'b1;
        if (cnt == 4'd15) nstate = END;
      end
      END:       odat_oe = 1'b1;
      NCRC:      if (cnt == 4'd1) nstate = WAIT_STAT;
      WAIT_STAT: if (!idat) nstate = STAT;
                 else if (tcnt == TMAX) nstate = DONE;
      STAT:      if (cnt == 4'd3) nstate = BUSY;
      BUSY:      if (idat || tcnt == TMAX) nstate = DONE;
      DONE:      nstate = IDLE;
      default:   nstate = IDLE;
    endcase
    if (state == END) nstate = NCRC;
  end

  assign obusy = (state != IDLE);
  assign odone = (state == DONE);
  assign oerr  = err;

  assign crc_next = {crc[14:0], 1'b0} ^ ({16{crc[15] ^ odat}} & 16'h1021);

  // Equivalent to holding the crc16 in reset outside DATA, done as a synchronous clear
  always_ff @(posedge iclk or posedge irst) begin
    if (irst)                crc <= '0;
    else if (state != DATA)  crc <= '0;
    else                     crc <= crc_next;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      bitcnt     <= '0;
      cnt        <= '0;
      tcnt       <= '0;
      shreg      <= '0;
      crcsh      <= '0;
      stat       <= '0;
      err        <= 1'b0;
      odata_addr <= '0;
    end else begin
      if (nstate != state) begin
        bitcnt <= '0;
        cnt    <= '0;
        tcnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
        if (state == DATA) bitcnt <= bitcnt + 1'b1;
        if (state == WAIT_STAT || state == BUSY) tcnt <= tcnt + 1'b1;
      end

      case (state)
        IDLE: if (istart) begin
          odata_addr <= '0;
          err        <= 1'b0;
        end
        START: begin
          shreg <= idata_byte;
          if (odata_addr != AMAX) odata_addr <= odata_addr + 1'b1;
        end
        DATA: begin
          if (bitcnt[2:0] == 3'd7) begin
            shreg <= idata_byte;
            if (odata_addr != AMAX) odata_addr <= odata_addr + 1'b1;
          end else begin
            shreg <= {shreg[6:0], 1'b0};
          end
          if (bitcnt == LAST_BIT) crcsh <= crc_next;
        end
        CRC:       crcsh <= {crcsh[14:0], 1'b0};
        WAIT_STAT: if (idat && tcnt == TMAX) err <= 1'b1;
        STAT: begin
          if (cnt != 4'd3)                stat <= {stat[1:0], idat};
          else if ({stat, idat} != 4'b0101) err <= 1'b1;
        end
        BUSY:      if (!idat && tcnt == TMAX) err <= 1'b1;
        // Parking the address at 0 lets the 1-cycle buffer present byte 0 during START
        DONE:      odata_addr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_tx.sv
// Randomised self-checking bench for sd_dat_tx against a reference model of the
// DAT0 stream (start bit, data, CRC16, end bit) and a scripted card response.
module tb_sd_dat_tx;

  localparam int NB   = 512;
  localparam int TO   = 100;
  localparam int LEN  = 1 + 8 * NB + 16 + 1;
  localparam int M_OK = 0, M_TO_STAT = 1, M_TO_BUSY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       istart = 1'b0;
  logic [8:0] addr;
  logic [7:0] rdata = '0;
  logic       odat, oe, idat = 1'b1, obusy, odone, oerr;

  logic [7:0] mem [0:NB-1];
  logic       obits [0:LEN+63];
  logic       ebits [0:LEN-1];
  logic [15:0] last_crc;
  int n_checks = 0;
  int n_pass   = 0;

  sd_dat_tx #(.BLOCK_BYTES(NB), .TIMEOUT(TO)) dut (
    .iclk(clk), .irst(rst), .istart(istart), .odata_addr(addr),
    .idata_byte(rdata), .odat(odat), .odat_oe(oe), .idat(idat),
    .obusy(obusy), .odone(odone), .oerr(oerr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rdata <= mem[addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic card_bit(input int n, input int d, input int mode,
                                    input logic [2:0] st, input logic eb, input int busy);
    int rel = n - (2 + d);
    if (mode == M_TO_STAT || rel < 0) return 1'b1;
    if (rel == 0) return 1'b0;
    if (rel <= 3) return st[3 - rel];
    if (rel == 4) return eb;
    if (mode == M_TO_BUSY) return 1'b0;
    return (rel - 5 < busy) ? 1'b0 : 1'b1;
  endfunction

  task automatic build_expected(output logic [15:0] c);
    logic [7:0] b;
    logic fb;
    c = '0;
    ebits[0] = 1'b0;
    for (int p = 0; p < 8 * NB; p++) begin
      b = mem[p / 8];
      ebits[1 + p] = b[7 - (p % 8)];
      fb = c[15] ^ ebits[1 + p];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    for (int j = 0; j < 16; j++) ebits[1 + 8 * NB + j] = c[15 - j];
    ebits[LEN - 1] = 1'b1;
  endtask

  task automatic xfer(input logic [2:0] st, input logic eb, input int busy, input int d,
                      input int mode, input int rst_at, input bit glitch);
    logic [15:0] mcrc, ocrc;
    int nb = 0, nbad = 0, nerr = 0, done_n = -1, exp_n, expa;
    logic dat_ncrc = 1'b0, err_s = 1'b0, busy_s = 1'b0, exp_err;
    build_expected(mcrc);
    @(negedge clk);
    istart = 1'b1;
    for (int n = 0; n < LEN + 50; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("busy_start", obusy, 1'b1);
        check("err_clear", oerr, 1'b0);
      end
      if (oe) begin
        if (nb < LEN + 64) obits[nb] = odat;
        expa = -1;
        if (nb == 0) expa = 0;
        else if (nb <= 8 * NB && (nb - 1) % 8 == 0) expa = ((nb - 1) / 8 + 1 > NB - 1) ? NB - 1 : (nb - 1) / 8 + 1;
        else if (nb == 8 * NB + 1) expa = NB - 1;
        if (expa >= 0 && int'(addr) != expa) nbad++;
        if (rst_at >= 0 && nb == rst_at) begin
          rst = 1'b1;
          istart = 1'b0;
          #1;
          check("rst_oe", oe, 1'b0);
          check("rst_dat", odat, 1'b1);
          check("rst_busy", obusy, 1'b0);
          @(negedge clk);
          rst = 1'b0;
          for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (odone || obusy) nerr++;
          end
          check("rst_quiet", nerr, 0);
          return;
        end
        nb++;
      end else if (nb > 0) begin
        dat_ncrc = odat;
        break;
      end
      istart = glitch && (nb == 100 || nb == 2000 || nb == 4000);
    end
    istart = 1'b0;
    for (int i = 0; i < LEN; i++) if (obits[i] !== ebits[i]) nerr++;
    for (int j = 0; j < 16; j++) ocrc[15 - j] = obits[1 + 8 * NB + j];
    last_crc = ocrc;
    check("oe_len", nb, LEN);
    check("start_bit", obits[0], 1'b0);
    check("stream", nerr, 0);
    check("crc", ocrc, mcrc);
    check("end_bit", obits[LEN - 1], 1'b1);
    check("ncrc_dat", dat_ncrc, 1'b1);
    check("addr_seq", nbad, 0);
    for (int n = 1; n < 400; n++) begin
      @(negedge clk);
      if (odone) begin
        done_n = n;
        err_s  = oerr;
        busy_s = obusy;
        break;
      end
      idat = card_bit(n, d, mode, st, eb, busy);
    end
    idat = 1'b1;
    if (mode == M_TO_STAT)      exp_n = 2 + TO;
    else if (mode == M_TO_BUSY) exp_n = 7 + d + TO;
    else                        exp_n = 8 + d + busy;
    exp_err = (mode != M_OK) || !(st == 3'b010 && eb);
    check("done_at", done_n, exp_n);
    check("err", err_s, exp_err);
    check("busy_in_done", busy_s, 1'b1);
    @(negedge clk);
    check("busy_after", obusy, 1'b0);
    check("done_pulse", odone, 1'b0);
    check("err_hold", oerr, exp_err);
  endtask

  initial begin
    for (int i = 0; i < NB; i++) mem[i] = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_dat0", odat, 1'b1);
    check("rst_oe0", oe, 1'b0);
    check("rst_addr0", addr, 9'd0);
    check("rst_busy0", obusy, 1'b0);
    check("rst_done0", odone, 1'b0);
    check("rst_err0", oerr, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    xfer(3'b010, 1'b1, 10, 1, M_OK, -1, 1'b0);
    check("crc_ff", last_crc, 16'h7FA1);

    for (int i = 0; i < NB; i++) mem[i] = 8'h00;
    xfer(3'b010, 1'b1, $urandom_range(0, 20), $urandom_range(0, 4), M_OK, -1, 1'b0);
    check("crc_00", last_crc, 16'h0000);

    for (int i = 0; i < NB; i++) mem[i] = 8'(i);
    xfer(3'b010, 1'b1, $urandom_range(0, 20), $urandom_range(0, 4), M_OK, -1, 1'b1);

    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
    xfer(3'b101, 1'b1, $urandom_range(0, 20), $urandom_range(0, 4), M_OK, -1, 1'b0);

    xfer(3'b010, 1'b1, 0, 0, M_TO_STAT, -1, 1'b0);
    xfer(3'b010, 1'b1, 0, $urandom_range(0, 4), M_TO_BUSY, -1, 1'b0);

    for (int i = 0; i < NB; i++) mem[i] = 8'(i);
    xfer(3'b010, 1'b1, 0, 0, M_OK, 1 + 200 * 8 + 3, 1'b0);
    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
    xfer(3'b010, 1'b1, $urandom_range(0, 20), $urandom_range(0, 4), M_OK, -1, 1'b0);

    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
    xfer(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 20),
         $urandom_range(0, 4), M_OK, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
